// File: rtl/xpb_table_gen_if.sv
`timescale 1ns/1ps
// Table-generation request and table-write bundle for xpb_table_gen.
// The generator uses the slave side; the requester / table RAM side uses the master side.
interface xpb_table_gen_if #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
);
  logic                start;
  logic [WIDTH-1:0]    base;
  logic [WIDTH-1:0]    modulus;
  logic                busy;
  logic                done;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;

  modport master (
    output start, base, modulus,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, base, modulus,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/xpb_table_gen.sv
`timescale 1ns/1ps
// Streams entry j = (j*B) mod M for j = 0..2^IDX_BITS-1 as table writes, one per 2 cycles after start.
// Latency: entry 0 one cycle after start, done 2^(IDX_BITS+1) cycles after start; no backpressure.
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  xpb_table_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EMIT0 = 3'd1,
    S_ADD   = 3'd2,
    S_RED   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;
  localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;

  logic [WIDTH-1:0]    r_base;
  logic [WIDTH-1:0]    r_mod;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH:0]      r_sum;

  logic                r_busy;
  logic                r_done;
  logic                r_wr_en;
  logic [IDX_BITS-1:0] r_wr_addr;
  logic [WIDTH-1:0]    r_wr_data;

  logic [WIDTH+1:0]    w_diff;
  logic                w_take_diff;
  logic [WIDTH-1:0]    w_red;
  logic [WIDTH:0]      w_sum_nxt;

  // sum < 2M, so one conditional subtract brings it back into [0, M).
  assign w_diff      = {1'b0, r_sum} - {2'b00, r_mod};
  assign w_take_diff = ~w_diff[WIDTH+1] & ~w_diff[WIDTH];
  assign w_red       = w_take_diff ? w_diff[WIDTH-1:0] : r_sum[WIDTH-1:0];
  assign w_sum_nxt   = {1'b0, r_acc} + {1'b0, r_base};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_EMIT0;
      S_EMIT0: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_RED;
      S_RED:   w_state_nxt = (r_wr_addr == LAST_IDX) ? S_FIN : S_ADD;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered against the state being entered, so each write
  // is visible during EMIT0 / RED and done during FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_mod     <= '0;
      r_acc     <= '0;
      r_sum     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base    <= bus.base;
            r_mod     <= bus.modulus;
            r_acc     <= '0;
            r_sum     <= '0;
            r_busy    <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
          end
        end
        S_EMIT0: begin
          r_sum <= w_sum_nxt;
        end
        S_ADD: begin
          r_acc     <= w_red;
          r_wr_data <= w_red;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_wr_addr + IDX_ONE;
        end
        S_RED: begin
          if (r_wr_addr == LAST_IDX) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_sum <= w_sum_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_xpb_table_gen.sv
`timescale 1ns/1ps
// Scoreboard bench: a 16-bit instance for directed corner cases and a 1024-bit instance
// for back-to-back random runs, both checked against a (j*B) mod M reference.
module tb_xpb_table_gen;

  typedef struct {
    int             cyc;
    int             addr;
    logic [1023:0]  data;
  } ent_t;

  logic clk     = 1'b0;
  logic rst_s_n = 1'b0;
  logic rst_l_n = 1'b0;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  ent_t q_s[$];
  ent_t q_l[$];
  int   s1_s  = 0;
  int   s1_l  = 0;
  bit   act_s = 1'b0;
  bit   act_l = 1'b0;

  xpb_table_gen_if #(.WIDTH(16),   .IDX_BITS(5)) s_if();
  xpb_table_gen_if #(.WIDTH(1024), .IDX_BITS(5)) l_if();

  xpb_table_gen #(.WIDTH(16),   .IDX_BITS(5)) u_s (.clk(clk), .rst_n(rst_s_n), .bus(s_if.slave));
  xpb_table_gen #(.WIDTH(1024), .IDX_BITS(5)) u_l (.clk(clk), .rst_n(rst_l_n), .bus(l_if.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (low 128 bits)", nm, got[127:0], exp[127:0]);
    end
  endtask

  // Reference: entry j = (j*B) mod M, appearing in cycle 2j+1 after the start edge.
  task automatic push(input bit big, input int s1, input logic [1023:0] b, input logic [1023:0] m);
    for (int j = 0; j < 32; j++) begin
      logic [1039:0] pr;
      ent_t e;
      pr     = 1040'(j) * {16'b0, b};
      e.cyc  = s1 + 2 * j;
      e.addr = j;
      e.data = 1024'(pr % {16'b0, m});
      if (big) q_l.push_back(e);
      else     q_s.push_back(e);
    end
  endtask

  task automatic mon(input bit big, input bit rstn, input bit act, input int s1,
                     input logic busy, input logic done, input logic wr_en,
                     input logic [4:0] addr, input logic [1023:0] data);
    string p;
    int    k;
    bit    eb, ed, ew;
    ent_t  e;
    p = big ? "w1024" : "w16";
    k = cyc - s1;
    if (!rstn) begin
      chk({p, ".rst_busy"},  busy,  0);
      chk({p, ".rst_done"},  done,  0);
      chk({p, ".rst_wr_en"}, wr_en, 0);
      chk({p, ".rst_addr"},  addr,  0);
      chk({p, ".rst_data"},  data,  0);
      return;
    end
    eb = act && k >= 0 && k <= 62;
    ed = act && k == 63;
    ew = eb && (k % 2 == 0);
    chk({p, ".busy"},  busy,  eb);
    chk({p, ".done"},  done,  ed);
    chk({p, ".wr_en"}, wr_en, ew);
    if (wr_en) begin
      if ((big && q_l.size() == 0) || (!big && q_s.size() == 0)) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s.unexpected_write: got addr %0d at cycle %0d, required no write", p, addr, cyc);
      end else begin
        if (big) e = q_l.pop_front();
        else     e = q_s.pop_front();
        chk({p, ".wr_cycle"}, cyc,  e.cyc);
        chk({p, ".wr_addr"},  addr, e.addr);
        chk({p, ".wr_data"},  data, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, rst_s_n, act_s, s1_s, s_if.busy, s_if.done, s_if.wr_en, s_if.wr_addr,
        {1008'b0, s_if.wr_data});
    mon(1'b1, rst_l_n, act_l, s1_l, l_if.busy, l_if.done, l_if.wr_en, l_if.wr_addr,
        l_if.wr_data);
  end

  task automatic start_s(input logic [15:0] b, input logic [15:0] m);
    @(negedge clk);
    s_if.base    = b;
    s_if.modulus = m;
    s_if.start   = 1'b1;
    @(posedge clk);
    #1;
    s1_s  = cyc;
    act_s = 1'b1;
    push(1'b0, s1_s, {1008'b0, b}, {1008'b0, m});
    @(negedge clk);
    s_if.start = 1'b0;
  endtask

  task automatic wait_s(input int n);
    while (cyc < s1_s + n) @(negedge clk);
  endtask

  task automatic rnd_pair(output logic [1023:0] b, output logic [1023:0] m);
    for (int i = 0; i < 32; i++) begin
      m[i*32 +: 32] = $urandom;
      b[i*32 +: 32] = $urandom;
    end
    m[0] = 1'b1;
    b    = b % m;
  endtask

  task automatic run_l();
    logic [1023:0] b, m;
    rnd_pair(b, m);
    @(negedge clk);
    l_if.base    = b;
    l_if.modulus = m;
    l_if.start   = 1'b1;
    for (int r = 0; r < 20; r++) begin
      if (r > 0) @(posedge clk);
      @(posedge clk);
      #1;
      s1_l  = cyc;
      act_l = 1'b1;
      push(1'b1, s1_l, b, m);
      while (cyc < s1_l + 63) @(negedge clk);
      if (r < 19) begin
        rnd_pair(b, m);
        l_if.base    = b;
        l_if.modulus = m;
      end else begin
        l_if.start = 1'b0;
      end
    end
    while (cyc < s1_l + 66) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b16;
    s_if.start = 1'b0; s_if.base = '0; s_if.modulus = '0;
    l_if.start = 1'b0; l_if.base = '0; l_if.modulus = '0;
    repeat (3) @(negedge clk);
    #2;
    rst_s_n = 1'b1;
    rst_l_n = 1'b1;
    #1;
    chk("w16.idle_addr",   s_if.wr_addr, 0);
    chk("w16.idle_data",   s_if.wr_data, 0);
    chk("w1024.idle_data", l_if.wr_data, 0);

    start_s(16'h1234, 16'hFFF1);
    wait_s(64);
    start_s(16'hFFF0, 16'hFFF1);
    wait_s(64);
    start_s(16'h0000, 16'hFFF1);
    wait_s(64);

    // Ignored starts and post-capture input changes.
    b16 = 16'($urandom_range(1, 16'hFFF0));
    start_s(b16, 16'hFFF1);
    wait_s(4);
    s_if.base    = 16'($urandom);
    s_if.modulus = 16'($urandom);
    wait_s(9);
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    wait_s(39);
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    wait_s(64);

    // Reset during an ADD cycle, then a clean rerun.
    b16 = 16'($urandom_range(1, 16'hFFF0));
    start_s(b16, 16'hFFF1);
    wait_s(19);
    #2;
    rst_s_n = 1'b0;
    act_s   = 1'b0;
    q_s.delete();
    #1;
    chk("w16.arst_busy",  s_if.busy,    0);
    chk("w16.arst_wr_en", s_if.wr_en,   0);
    chk("w16.arst_addr",  s_if.wr_addr, 0);
    chk("w16.arst_data",  s_if.wr_data, 0);
    repeat (3) @(negedge clk);
    #2;
    rst_s_n = 1'b1;
    b16 = 16'($urandom_range(1, 16'hFFF0));
    start_s(b16, 16'hFFF1);
    wait_s(66);

    run_l();

    chk("w16.pending_writes",   q_s.size(), 0);
    chk("w1024.pending_writes", q_l.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
